// File: rtl/mmio_master.sv
// mmio_master: single-outstanding MMIO bus initiator for the {BASE_HI,offset} register window.
// Latency: write response 1 cycle after command acceptance; read 2 cycles with a 1-cycle responder; timeout after 1+TIMEOUT cycles.
// Backpressure: cmd_ready is high only in IDLE; a response stays on rsp_* until rsp_ready, and nothing new is accepted meanwhile.
// Ports:
//   clk, rst (async active-low)
//   cmd_valid/cmd_ready/cmd_wr/cmd_offset/cmd_wdata   host command port
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err             host response port
//   addr_out/data_out/wr_out/rd_out                   responder strobes and bus
//   rd_valid_in/data_in                               responder read return
//   busy                                              high outside IDLE
module mmio_master #(
  parameter logic [15:0] BASE_HI = 16'hBEEF,
  parameter int          TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_offset,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] addr_out,
  output logic [31:0] data_out,
  output logic        wr_out,
  output logic        rd_out,
  input  logic        rd_valid_in,
  input  logic [31:0] data_in,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // The counter equals TIMEOUT on the edge that fails the read, so the
  // decision is taken while it still holds TIMEOUT-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_wr;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wr_stb;
  logic        r_rd_stb;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_accept;
  logic        w_timeout;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_timeout = (r_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_ISSUE;
      S_ISSUE: w_next = r_wr ? S_RESP : S_WAIT;
      // rd_valid_in wins over a timeout landing on the same edge
      S_WAIT:  if (rd_valid_in || w_timeout) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; cmd_ready is gated so it only rises once reset releases
  always_comb begin
    cmd_ready = (r_state == S_IDLE) && rst;
    busy      = (r_state != S_IDLE);
    rsp_valid = (r_state == S_RESP);
  end

  // Datapath: command latch, strobes, WAIT counter and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr     <= 1'b0;
      r_cnt    <= 8'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_wr_stb <= 1'b0;
      r_rd_stb <= 1'b0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr     <= cmd_wr;
            r_addr   <= {BASE_HI, cmd_offset};
            r_wdata  <= cmd_wdata;
            r_wr_stb <= cmd_wr;
            r_rd_stb <= !cmd_wr;
          end
        end
        S_ISSUE: begin
          r_wr_stb <= 1'b0;
          r_rd_stb <= 1'b0;
          r_cnt    <= 8'd0;
          if (r_wr) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (rd_valid_in) begin
            r_rdata <= data_in;
            r_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_timeout) begin
              r_rdata <= 32'd0;
              r_err   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign addr_out  = r_addr;
  assign data_out  = r_wdata;
  assign wr_out    = r_wr_stb;
  assign rd_out    = r_rd_stb;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
